cpu_io_ctrl: RTL

Byte-I/O controller between the CPU execute stage and the UART transmitter/receiver. It accepts execute-stage write requests (`w_req`/`w_data`), queues them and drives the UART TX valid/ready handshake. It latches received bytes into the `r_data` special register and raises `irr` until the CPU acknowledges. It produces `w_busy`, `irr` and `r_data` for the special-register file, plus a gated interrupt request.

---
 rtl/cpu_io_ctrl_pkg.sv | 19 +
 rtl/io_tx_fifo.sv | 54 +++++
 rtl/cpu_io_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cpu_io_ctrl_pkg.sv
// Shared CPU I/O types: TX state encoding, status bundle for the
// special-register file, and the default TX queue depth.
package cpu_io_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } IO_TX_STATE;

  typedef struct packed {
    logic       w_busy;
    logic       irr;
    logic       rx_ovr;
    logic [7:0] r_data;
  } IO_STATUS;

  localparam int unsigned IO_TX_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/io_tx_fifo.sv
// Synchronous FIFO for queued TX bytes. Pointers carry one extra wrap bit
// so full and empty are distinguished without a separate counter.
module io_tx_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  // A push while full is dropped; the pop in the same cycle still proceeds.
  assign w_push  = i_push & ~w_full;
  assign w_pop   = i_pop & ~w_empty;

  // Pointer advance; wrap modulo 2*DEPTH comes from the natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/cpu_io_ctrl.sv
// Byte-I/O controller between the execute stage and the UART.
// Build option: define CPU_IO_TX_FIFO_EN to replace the single TX holding
// register (IDLE/SEND FSM) with a TX_DEPTH-entry FIFO.
module cpu_io_ctrl
  import cpu_io_ctrl_pkg::*;
#(
  parameter int unsigned TX_DEPTH = IO_TX_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       w_req,
  input  logic [7:0] w_data,
  input  logic       ack,
  input  logic       intr_en,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       w_busy,
  output logic       irr,
  output logic [7:0] r_data,
  output logic       rx_ovr,
  output logic       intr_req
);

  // Elaboration guard: queue depth must be a power of two, at least 2.
  if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_depth_check
    $error("cpu_io_ctrl: TX_DEPTH must be a power of two >= 2");
  end

  logic       w_tx_busy;
  logic       w_tx_valid;
  logic [7:0] w_tx_data;
  logic       r_irr;
  logic       r_rx_ovr;
  logic [7:0] r_rx_byte;
  IO_STATUS   w_status;

`ifdef CPU_IO_TX_FIFO_EN
  logic w_fifo_full;
  logic w_fifo_empty;

  io_tx_fifo #(
    .DATA_W (8),
    .DEPTH  (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_req),
    .i_data  (w_data),
    .i_pop   (tx_ready),
    .o_data  (w_tx_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_tx_valid = ~w_fifo_empty;
  assign w_tx_busy  = w_fifo_full;
`else
  IO_TX_STATE r_state;
  IO_TX_STATE w_state_nxt;
  logic [7:0] r_tx_byte;

  // TX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and handshake outputs; busy depends on registered state only,
  // so a request coinciding with the draining handshake is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_valid  = 1'b0;
    w_tx_busy   = 1'b0;
    case (r_state)
      IDLE: if (w_req) w_state_nxt = SEND;
      SEND: begin
        w_tx_valid = 1'b1;
        w_tx_busy  = 1'b1;
        if (tx_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Holding register captures the byte only when a request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_tx_byte <= '0;
    else if (r_state == IDLE && w_req) r_tx_byte <= w_data;
  end

  assign w_tx_data = r_tx_byte;
`endif

  // RX latch: accept when nothing is pending or the CPU is acking this cycle;
  // otherwise the byte is lost and the sticky overrun flag is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irr     <= 1'b0;
      r_rx_ovr  <= 1'b0;
      r_rx_byte <= '0;
    end else begin
      if (rx_valid && (!r_irr || ack)) begin
        r_rx_byte <= rx_data;
        r_irr     <= 1'b1;
      end else if (ack) begin
        r_irr     <= 1'b0;
      end
      if (ack)                   r_rx_ovr <= 1'b0;
      else if (rx_valid && r_irr) r_rx_ovr <= 1'b1;
    end
  end

  assign w_status = '{w_busy: w_tx_busy, irr: r_irr, rx_ovr: r_rx_ovr,
                      r_data: r_rx_byte};

  assign tx_valid = w_tx_valid;
  assign tx_data  = w_tx_data;
  assign w_busy   = w_status.w_busy;
  assign irr      = w_status.irr;
  assign rx_ovr   = w_status.rx_ovr;
  assign r_data   = w_status.r_data;
  assign intr_req = w_status.irr & intr_en;

endmodule
